// File: rtl/regfile_2r1w_pkg.sv
// Shared types and helpers for the 2-read/1-write register file.
//   sweep_state_t : init sweep FSM states (IDLE, SWEEP)
//   calc_aw()     : select width for a given entry count, never below 1
package regfile_2r1w_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

    // Smallest aw with 2**aw >= depth, clamped to at least 1 bit.
    function automatic int unsigned calc_aw(input int unsigned depth);
        int unsigned aw;
        aw = 1;
        while ((32'd1 << aw) < depth) begin
            aw = aw + 1;
        end
        return aw;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// Single registered read port of the register file.
//   clk, clr          : clock, async active-high reset
//   rsel              : read index
//   mem, vld          : current entry contents and valid bits
//   wr_en/sel/data    : write taking effect on this edge (forwarded)
//   q, valid          : registered read data / valid, one cycle latency
module regfile_rdport
    import regfile_2r1w_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 8,
    parameter bit          R0_ZERO = 1'b0,
    parameter int unsigned AW      = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [AW-1:0]    rsel,
    input  logic [WIDTH-1:0] mem [DEPTH],
    input  logic [DEPTH-1:0] vld,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic             in_range_c;
    logic [WIDTH-1:0] rd_data_c;
    logic             rd_vld_c;

    // DEPTH need not be a power of two, so the index space can exceed it.
    assign in_range_c = (32'(rsel) < DEPTH);

    // Read mux: range check, then hard-wired zero entry, then write-first forwarding.
    always_comb begin
        rd_data_c = '0;
        rd_vld_c  = 1'b0;
        if (!in_range_c) begin
            rd_data_c = '0;
            rd_vld_c  = 1'b0;
        end else if (R0_ZERO && (rsel == '0)) begin
            rd_data_c = '0;
            rd_vld_c  = 1'b1;
        end else if (wr_en && (wr_sel == rsel)) begin
            rd_data_c = wr_data;
            rd_vld_c  = 1'b1;
        end else begin
            rd_data_c = mem[rsel];
            rd_vld_c  = vld[rsel];
        end
    end

    // Output register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q     <= '0;
            valid <= 1'b0;
        end else begin
            q     <= rd_data_c;
            valid <= rd_vld_c;
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with two registered read ports, one write port, per-entry
// valid bits and a hardware init sweep that fills every entry with INIT_VAL.
//   clk, clr        : clock, async active-high reset
//   en, wsel, d     : write enable / index / data
//   rsel0, rsel1    : read indices
//   q0, q1          : registered read data
//   valid0, valid1  : registered valid of the entry read
//   init_req        : one-cycle request to start the init sweep
//   busy            : high while the sweep runs (exactly DEPTH cycles)
module regfile_2r1w
    import regfile_2r1w_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      DEPTH    = 8,
    parameter bit               R0_ZERO  = 1'b0,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    localparam int unsigned     AW       = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [AW-1:0]    wsel,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    rsel0,
    input  logic [AW-1:0]    rsel1,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic             valid0,
    output logic             valid1,
    input  logic             init_req,
    output logic             busy
);

    sweep_state_t     state;
    sweep_state_t     state_nxt;
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    ptr_nxt;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] vld;

    logic             init_acc_c;
    logic             sweep_wr_c;
    logic             ext_wr_c;
    logic             wr_en_c;
    logic [AW-1:0]    wr_sel_c;
    logic [WIDTH-1:0] wr_data_c;

    // Sweep FSM state register; busy is registered alongside the state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            busy  <= (state_nxt == SWEEP);
        end
    end

    // Sweep FSM next state: init_req is only honoured from IDLE.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (init_req) begin
                    state_nxt = SWEEP;
                    ptr_nxt   = '0;
                end
            end
            SWEEP: begin
                if (32'(ptr) == (DEPTH - 1)) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + AW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    // Write arbitration: the sweep owns the write port; an accepted init_req drops the external write.
    always_comb begin
        init_acc_c = (state == IDLE) && init_req;
        sweep_wr_c = (state == SWEEP) && !(R0_ZERO && (ptr == '0));
        ext_wr_c   = en && (state == IDLE) && !init_acc_c
                     && (32'(wsel) < DEPTH)
                     && !(R0_ZERO && (wsel == '0));
        wr_en_c    = sweep_wr_c || ext_wr_c;
        wr_sel_c   = sweep_wr_c ? ptr : wsel;
        wr_data_c  = sweep_wr_c ? INIT_VAL : d;
    end

    // Storage array and valid bits.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mem <= '{default: '0};
            vld <= '0;
        end else if (wr_en_c) begin
            mem[wr_sel_c] <= wr_data_c;
            vld[wr_sel_c] <= 1'b1;
        end
    end

    regfile_rdport #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .R0_ZERO (R0_ZERO),
        .AW      (AW)
    ) u_rdport0 (
        .clk     (clk),
        .clr     (clr),
        .rsel    (rsel0),
        .mem     (mem),
        .vld     (vld),
        .wr_en   (wr_en_c),
        .wr_sel  (wr_sel_c),
        .wr_data (wr_data_c),
        .q       (q0),
        .valid   (valid0)
    );

    regfile_rdport #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .R0_ZERO (R0_ZERO),
        .AW      (AW)
    ) u_rdport1 (
        .clk     (clk),
        .clr     (clr),
        .rsel    (rsel1),
        .mem     (mem),
        .vld     (vld),
        .wr_en   (wr_en_c),
        .wr_sel  (wr_sel_c),
        .wr_data (wr_data_c),
        .q       (q1),
        .valid   (valid1)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: one 8-entry instance (INIT_VAL 0x5A) and
// one 6-entry instance with a hard-wired zero entry (INIT_VAL 0x3C).
module tb_regfile_2r1w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: DEPTH 8, R0_ZERO 0
    logic       clr_a = 1'b0, en_a = 1'b0, init_a = 1'b0;
    logic [2:0] wsel_a = '0, rsel0_a = '0, rsel1_a = '0;
    logic [7:0] d_a = '0, q0_a, q1_a;
    logic       v0_a, v1_a, busy_a;

    // Instance B: DEPTH 6, R0_ZERO 1
    logic       clr_b = 1'b0, en_b = 1'b0, init_b = 1'b0;
    logic [2:0] wsel_b = '0, rsel0_b = '0, rsel1_b = '0;
    logic [7:0] d_b = '0, q0_b, q1_b;
    logic       v0_b, v1_b, busy_b;

    regfile_2r1w #(.WIDTH(8), .DEPTH(8), .R0_ZERO(1'b0), .INIT_VAL(8'h5A)) dut_a (
        .clk(clk), .clr(clr_a), .en(en_a), .wsel(wsel_a), .d(d_a),
        .rsel0(rsel0_a), .rsel1(rsel1_a), .q0(q0_a), .q1(q1_a),
        .valid0(v0_a), .valid1(v1_a), .init_req(init_a), .busy(busy_a)
    );

    regfile_2r1w #(.WIDTH(8), .DEPTH(6), .R0_ZERO(1'b1), .INIT_VAL(8'h3C)) dut_b (
        .clk(clk), .clr(clr_b), .en(en_b), .wsel(wsel_b), .d(d_b),
        .rsel0(rsel0_b), .rsel1(rsel1_b), .q0(q0_b), .q1(q1_b),
        .valid0(v0_b), .valid1(v1_b), .init_req(init_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int busy_cnt;
    int guard;
    logic [7:0] exp_q;
    logic       exp_v;

    initial begin
        // Reset both instances with a clean rising edge on clr
        #1;
        clr_a = 1'b1;
        clr_b = 1'b1;
        #1;
        check("rst_q0",   64'(q0_a),   64'h0);
        check("rst_q1",   64'(q1_a),   64'h0);
        check("rst_v0",   64'(v0_a),   64'h0);
        check("rst_v1",   64'(v1_a),   64'h0);
        check("rst_busy", 64'(busy_a), 64'h0);
        tick();
        clr_a = 1'b0;
        clr_b = 1'b0;

        // ---------------- Instance A ----------------
        // Basic write then read
        en_a = 1'b1; wsel_a = 3'd1; d_a = 8'h01;
        tick();
        en_a = 1'b0; rsel0_a = 3'd1; rsel1_a = 3'd2;
        tick();
        check("wr_rd_q0", 64'(q0_a), 64'h01);
        check("wr_rd_v0", 64'(v0_a), 64'h1);
        check("wr_rd_q1", 64'(q1_a), 64'h00);
        check("wr_rd_v1", 64'(v1_a), 64'h0);

        // Write-first forwarding on both ports
        en_a = 1'b1; wsel_a = 3'd3; d_a = 8'hA5; rsel0_a = 3'd3; rsel1_a = 3'd3;
        tick();
        en_a = 1'b0;
        check("fwd_q0", 64'(q0_a), 64'hA5);
        check("fwd_v0", 64'(v0_a), 64'h1);
        check("fwd_q1", 64'(q1_a), 64'hA5);
        check("fwd_v1", 64'(v1_a), 64'h1);

        // Last entry; entry 0 is ordinary storage here and was never written
        en_a = 1'b1; wsel_a = 3'd7; d_a = 8'h77;
        tick();
        en_a = 1'b0; rsel0_a = 3'd7; rsel1_a = 3'd0;
        tick();
        check("last_q0", 64'(q0_a), 64'h77);
        check("last_v0", 64'(v0_a), 64'h1);
        check("e0_q1",   64'(q1_a), 64'h00);
        check("e0_v1",   64'(v1_a), 64'h0);

        // Sweep, started on the same edge as an external write to entry 2
        busy_cnt = 0;
        init_a = 1'b1; en_a = 1'b1; wsel_a = 3'd2; d_a = 8'h33;
        tick();
        init_a = 1'b0;
        if (busy_a) busy_cnt++;
        wsel_a = 3'd4; d_a = 8'h44; rsel0_a = 3'd0; rsel1_a = 3'd5;
        tick();
        if (busy_a) busy_cnt++;
        check("swp_fwd_q0", 64'(q0_a), 64'h5A);
        check("swp_fwd_v0", 64'(v0_a), 64'h1);
        check("swp_e5_q1",  64'(q1_a), 64'h00);
        check("swp_e5_v1",  64'(v1_a), 64'h0);
        guard = 0;
        while (busy_a && guard < 20) begin
            init_a = (guard == 2);
            tick();
            if (busy_a) busy_cnt++;
            guard++;
        end
        init_a = 1'b0;
        en_a   = 1'b0;
        check("swp_busy_cycles", 64'(busy_cnt), 64'd8);
        check("swp_busy_end",    64'(busy_a),   64'h0);
        for (int i = 0; i < 8; i++) begin
            rsel0_a = 3'(i);
            rsel1_a = 3'(7 - i);
            tick();
            check($sformatf("swp_q0[%0d]", i),     64'(q0_a), 64'h5A);
            check($sformatf("swp_v0[%0d]", i),     64'(v0_a), 64'h1);
            check($sformatf("swp_q1[%0d]", 7 - i), 64'(q1_a), 64'h5A);
            check($sformatf("swp_v1[%0d]", 7 - i), 64'(v1_a), 64'h1);
        end

        // Reset in the middle of a sweep
        rsel0_a = 3'd1; rsel1_a = 3'd6;
        init_a = 1'b1;
        tick();
        init_a = 1'b0;
        tick();
        tick();
        check("mid_pre_busy", 64'(busy_a), 64'h1);
        check("mid_pre_q0",   64'(q0_a),   64'h5A);
        #2;
        clr_a = 1'b1;
        #1;
        check("mid_busy", 64'(busy_a), 64'h0);
        check("mid_q0",   64'(q0_a),   64'h0);
        check("mid_q1",   64'(q1_a),   64'h0);
        check("mid_v0",   64'(v0_a),   64'h0);
        check("mid_v1",   64'(v1_a),   64'h0);
        en_a = 1'b1; wsel_a = 3'd4; d_a = 8'hEE;
        tick();
        tick();
        en_a = 1'b0;
        clr_a = 1'b0;
        tick();
        tick();
        tick();
        check("post_clr_busy", 64'(busy_a), 64'h0);
        for (int i = 0; i < 8; i++) begin
            rsel0_a = 3'(i);
            rsel1_a = 3'(i);
            tick();
            check($sformatf("clr_q0[%0d]", i), 64'(q0_a), 64'h0);
            check($sformatf("clr_v0[%0d]", i), 64'(v0_a), 64'h0);
            check($sformatf("clr_v1[%0d]", i), 64'(v1_a), 64'h0);
        end

        // ---------------- Instance B ----------------
        // Writes to entry 0 and out-of-range index 7 are dropped
        en_b = 1'b1; wsel_b = 3'd0; d_b = 8'hFF;
        tick();
        wsel_b = 3'd7;
        tick();
        wsel_b = 3'd3; d_b = 8'h13;
        tick();
        wsel_b = 3'd5; d_b = 8'h55;
        tick();
        en_b = 1'b0; rsel0_b = 3'd0; rsel1_b = 3'd7;
        tick();
        check("b_r0_q0",  64'(q0_b), 64'h0);
        check("b_r0_v0",  64'(v0_b), 64'h1);
        check("b_oor_q1", 64'(q1_b), 64'h0);
        check("b_oor_v1", 64'(v1_b), 64'h0);
        for (int i = 1; i < 6; i++) begin
            rsel0_b = 3'(i);
            rsel1_b = 3'(i);
            tick();
            exp_q = (i == 3) ? 8'h13 : (i == 5) ? 8'h55 : 8'h00;
            exp_v = (i == 3) || (i == 5);
            check($sformatf("b_q0[%0d]", i), 64'(q0_b), 64'(exp_q));
            check($sformatf("b_v0[%0d]", i), 64'(v0_b), 64'(exp_v));
            check($sformatf("b_q1[%0d]", i), 64'(q1_b), 64'(exp_q));
        end

        // No forwarding into the zero entry or past the last entry
        en_b = 1'b1; wsel_b = 3'd0; d_b = 8'hFF; rsel0_b = 3'd0;
        tick();
        check("b_fwd_r0_q0", 64'(q0_b), 64'h0);
        check("b_fwd_r0_v0", 64'(v0_b), 64'h1);
        wsel_b = 3'd6; d_b = 8'hAB; rsel0_b = 3'd2; rsel1_b = 3'd6;
        tick();
        en_b = 1'b0;
        check("b_fwd_oor_q1", 64'(q1_b), 64'h0);
        check("b_fwd_oor_v1", 64'(v1_b), 64'h0);
        check("b_e2_v0",      64'(v0_b), 64'h0);

        // Sweep still lasts DEPTH cycles with the zero entry skipped
        busy_cnt = 0;
        init_b = 1'b1;
        tick();
        init_b = 1'b0;
        if (busy_b) busy_cnt++;
        guard = 0;
        while (busy_b && guard < 20) begin
            tick();
            if (busy_b) busy_cnt++;
            guard++;
        end
        check("b_busy_cycles", 64'(busy_cnt), 64'd6);
        for (int i = 0; i < 6; i++) begin
            rsel0_b = 3'(i);
            rsel1_b = 3'(5 - i);
            tick();
            exp_q = (i == 0) ? 8'h00 : 8'h3C;
            check($sformatf("b_swp_q0[%0d]", i), 64'(q0_b), 64'(exp_q));
            check($sformatf("b_swp_v0[%0d]", i), 64'(v0_b), 64'h1);
            check($sformatf("b_swp_v1[%0d]", 5 - i), 64'(v1_b), 64'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter WIDTH, default 8: data bits per entry (1..64).
REQ-002 Parameter DEPTH, default 8: number of entries (2..256; need not be a power of two).
REQ-003 Parameter R0_ZERO, default 0: when 1, entry 0 always reads 0, is always valid, and ignores writes.
REQ-004 Parameter INIT_VAL, default 0: WIDTH-bit value written by the init sweep.
REQ-005 Derived AW = max(1, clog2(DEPTH)): select width.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 clr  in  1  reset, asynchronous, active-high.
REQ-008 en  in  1  write enable.
REQ-009 wsel  in  AW  write index.
REQ-010 d  in  WIDTH  write data.
REQ-011 rsel0, rsel1  in  AW each  read indices, ports 0/1.
REQ-012 q0, q1  out  WIDTH each  registered read data.
REQ-013 valid0, valid1  out  1 each  registered valid flag of the entry read.
REQ-014 init_req  in  1  one-cycle request to start the init sweep.
REQ-015 busy  out  1  high while the init sweep runs.

Function
REQ-016 Write: on a clock edge with en=1, busy=0, no accepted init_req, and wsel<DEPTH, the entry at wsel takes d and its valid bit is set.
REQ-017 Writes with wsel>=DEPTH, or to entry 0 when R0_ZERO=1, are dropped with no state change.
REQ-018 Read latency is 1 cycle: at each edge, qN/validN load the content/valid of entry rselN as sampled at that edge.
REQ-019 Write-first forwarding: if the same edge writes entry rselN, qN takes d and validN takes 1.
REQ-020 A read with rselN>=DEPTH returns qN=0, validN=0.
REQ-021 When rselN=0 and R0_ZERO=1, the port returns qN=0, validN=1.
REQ-022 Both ports operate independently; equal rsel0/rsel1 returns identical data.
REQ-023 Sweep FSM states: IDLE and SWEEP; pointer ptr is AW bits wide.
REQ-024 IDLE->SWEEP when init_req=1 at an edge; ptr is set to 0 and busy rises in the following cycle.
REQ-025 In SWEEP, each edge writes INIT_VAL to entry ptr and sets its valid bit, then increments ptr.
REQ-026 When ptr=DEPTH-1, that edge writes the last entry and the FSM returns to IDLE; busy is high for exactly DEPTH cycles.
REQ-027 When R0_ZERO=1, the sweep skips the entry 0 write but still takes DEPTH cycles.
REQ-028 init_req while busy=1 is ignored.
REQ-029 init_req and en asserted on the same edge: the sweep starts and the write is dropped.
REQ-030 External writes while busy=1 are dropped; reads continue and return current contents, forwarding the sweep write per REQ-019.

Reset
REQ-031 When clr=1, immediately and regardless of clk: all entries are 0, all valid bits are 0, q0=q1=0, valid0=valid1=0, FSM is IDLE, ptr=0, busy=0.
REQ-032 clr asserted mid-sweep aborts the sweep; after release the FSM stays IDLE until a new init_req.
REQ-033 With clr=1, no write, read, or sweep takes effect.

Structure
REQ-034 A shared package holds the FSM state enum (IDLE, SWEEP) and the AW derivation function; WIDTH/DEPTH defaults are module parameters, not package constants.
REQ-035 One sub-module, regfile_rdport, implements a single registered read port with forwarding and range/R0 checks, instantiated twice.

Verification
REQ-036 Basic write then read: clr pulse, en=1 wsel=1 d=0x01, next cycle en=0 rsel0=1 -> one cycle later q0=0x01, valid0=1; rsel1=2 -> q1=0x00, valid1=0.
REQ-037 Forwarding: en=1 wsel=3 d=0xA5 with rsel0=3 on the same edge -> after that edge q0=0xA5, valid0=1.
REQ-038 Sweep with INIT_VAL=0x5A, DEPTH=8: pulse init_req -> busy high for exactly 8 cycles, writes during busy dropped; afterward every entry reads 0x5A with valid=1.
REQ-039 Reset mid-sweep: assert clr at sweep cycle 3 -> busy=0, q0=q1=0 and all valid=0 immediately; after release all entries read 0 with valid=0.
REQ-040 DEPTH=6, R0_ZERO=1: write d=0xFF to wsel=0 and wsel=7 -> rsel0=0 gives q0=0, valid0=1; rsel1=7 gives q1=0, valid1=0; no other entry changes.
REQ-041 init_req and en=1 wsel=2 d=0x33 on the same edge -> sweep runs; after completion entry 2 holds INIT_VAL, not 0x33.
